// File: rtl/sel_decoder_pkg.sv
// Shared definitions for the sequential select decoder: mode encodings,
// FSM state type and the one-hot helper used by the output decode.
package sel_decoder_pkg;

  // Encodings of the Mode input.
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // Operating states of the decoder.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_PULSE = 2'b10,
    ST_SCAN  = 2'b11
  } state_e;

  // Widest one-hot vector the helper can produce; callers cast down to OUT_N.
  localparam int ONEHOT_MAX = 64;

  // One-hot of idx, all-zero when idx falls outside 0..out_n-1.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [7:0] idx, input int out_n);
    logic [ONEHOT_MAX-1:0] res;
    res = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      res[i] = (i < out_n) && (int'(idx) == i);
    end
    return res;
  endfunction

endpackage

// File: rtl/sel_scan_counter.sv
// SCAN step divider plus wrapping select index. The index wraps at OUT_N-1,
// not at the top of the SEL_W range. The next index is exported so the top
// can register the matching one-hot in the same edge as the index.
module sel_scan_counter #(
  parameter int SEL_W    = 4,
  parameter int OUT_N    = 2**SEL_W,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [SEL_W-1:0] load_idx,
  input  logic             step,
  output logic [SEL_W-1:0] idx_q,
  output logic [SEL_W-1:0] idx_d
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Next divider/index: clear beats load beats step; when idle the divider rests at 0.
  always_comb begin
    idx_d = idx_q;
    div_d = div_q;
    if (clr) begin
      idx_d = '0;
      div_d = '0;
    end else if (load) begin
      idx_d = load_idx;
      div_d = '0;
    end else if (step) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = '0;
    end
  end

  // Divider and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      div_q <= '0;
    end else begin
      idx_q <= idx_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/sel_decoder_seq.sv
// Registered N-to-OUT_N one-hot decoder with HOLD, PULSE and SCAN modes.
// Optional feature macro: SEL_DECODER_RANGE_ERR_EN enables the sticky
// Range_Error flag; without it Range_Error is tied low.
module sel_decoder_seq
  import sel_decoder_pkg::*;
#(
  parameter int SEL_W    = 4,
  parameter int OUT_N    = 2**SEL_W,
  parameter int SCAN_DIV = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic             Load,
  input  logic [SEL_W-1:0] Decoder_Input,
  output logic [OUT_N-1:0] Decoder_Output,
  output logic             Out_Valid,
  output logic [SEL_W-1:0] Scan_Index,
  output logic             Range_Error
);

  state_e           state_q, state_d;
  logic [OUT_N-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             rerr_q, rerr_d;

  logic             in_range;
  logic             load_ok;
  logic             cnt_clr, cnt_load, cnt_step;
  logic [SEL_W-1:0] cnt_idx_q, cnt_idx_d;
  logic [OUT_N-1:0] oh_load, oh_scan;

  assign in_range = (32'(Decoder_Input) < 32'(OUT_N));
  assign load_ok  = Load & in_range;

  // Next state from Enable/Mode and the scan counter commands that go with it.
  always_comb begin
    state_d  = ST_IDLE;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    if (Enable) begin
      case (Mode)
        MODE_HOLD:  state_d = ST_HOLD;
        MODE_PULSE: state_d = ST_PULSE;
        MODE_SCAN:  state_d = ST_SCAN;
        default:    state_d = ST_IDLE;
      endcase
    end else begin
      state_d = ST_IDLE;
    end
    case (state_d)
      ST_HOLD, ST_PULSE: begin
        cnt_load = load_ok;
      end
      ST_SCAN: begin
        cnt_load = load_ok;
        if (state_q != ST_SCAN) begin
          cnt_clr = ~load_ok;
        end else begin
          cnt_step = ~load_ok;
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // Output decode for the state being entered; old-mode output never carries over.
  always_comb begin
    dout_d  = '0;
    oh_load = OUT_N'(onehot(8'(Decoder_Input), OUT_N));
    oh_scan = OUT_N'(onehot(8'(cnt_idx_d), OUT_N));
    case (state_d)
      ST_HOLD: begin
        if (Load) begin
          dout_d = load_ok ? oh_load : '0;
        end else if (state_q == ST_HOLD) begin
          dout_d = dout_q;
        end else begin
          dout_d = '0;
        end
      end
      ST_PULSE: begin
        dout_d = load_ok ? oh_load : '0;
      end
      ST_SCAN: begin
        dout_d = oh_scan;
      end
      default: begin
        dout_d = '0;
      end
    endcase
    valid_d = |dout_d;
`ifdef SEL_DECODER_RANGE_ERR_EN
    rerr_d = rerr_q | (Enable & Load & ~in_range);
`else
    rerr_d = 1'b0;
`endif
  end

  // FSM state and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
    end
  end

  sel_scan_counter #(
    .SEL_W    (SEL_W),
    .OUT_N    (OUT_N),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_counter (
    .clk      (Clock),
    .rst      (Reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_idx (Decoder_Input),
    .step     (cnt_step),
    .idx_q    (cnt_idx_q),
    .idx_d    (cnt_idx_d)
  );

  assign Decoder_Output = dout_q;
  assign Out_Valid      = valid_q;
  assign Scan_Index     = cnt_idx_q;
  assign Range_Error    = rerr_q;

endmodule

// File: tb/tb_sel_decoder_seq.sv
// Bench for sel_decoder_seq: two instances (16 outputs / divide-by-4 and
// 10 outputs / divide-by-2) share stimulus; a cycle model pushes expected
// outputs into a scoreboard queue that is drained after every clock edge.
module tb_sel_decoder_seq;

`ifdef SEL_DECODER_RANGE_ERR_EN
  localparam bit RERR_EN = 1'b1;
`else
  localparam bit RERR_EN = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic [1:0]  Mode;
  logic        Load;
  logic [3:0]  Decoder_Input;

  logic [15:0] dout16;
  logic        vld16;
  logic [3:0]  idx16;
  logic        err16;
  logic [9:0]  dout10;
  logic        vld10;
  logic [3:0]  idx10;
  logic        err10;

  sel_decoder_seq #(.SEL_W(4), .OUT_N(16), .SCAN_DIV(4)) u_dut16 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Load(Load),
    .Decoder_Input(Decoder_Input), .Decoder_Output(dout16), .Out_Valid(vld16),
    .Scan_Index(idx16), .Range_Error(err16)
  );

  sel_decoder_seq #(.SEL_W(4), .OUT_N(10), .SCAN_DIV(2)) u_dut10 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .Load(Load),
    .Decoder_Input(Decoder_Input), .Decoder_Output(dout10), .Out_Valid(vld10),
    .Scan_Index(idx10), .Range_Error(err10)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] out0;
    logic [3:0]  idx0;
    logic        err0;
    logic [15:0] out1;
    logic [3:0]  idx1;
    logic        err1;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  int          m_n[2];
  int          m_sd[2];
  int          m_st[2];
  int          m_idx[2];
  int          m_div[2];
  logic        m_err[2];
  logic [15:0] m_out[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = 0;
      m_idx[k] = 0;
      m_div[k] = 0;
      m_err[k] = 1'b0;
      m_out[k] = 16'h0000;
    end
  endtask

  // States: 0 idle, 1 hold, 2 pulse, 3 scan.
  task automatic model_step(input int k);
    int nxt;
    bit inr;
    nxt = (!Enable || Mode == 2'b11) ? 0 : int'(Mode) + 1;
    inr = Load && (int'(Decoder_Input) < m_n[k]);
    if (RERR_EN && Enable && Load && !inr) m_err[k] = 1'b1;
    case (nxt)
      1: begin
        if (Load) m_out[k] = inr ? (16'h0001 << Decoder_Input) : 16'h0000;
        else if (m_st[k] != 1) m_out[k] = 16'h0000;
        if (inr) m_idx[k] = int'(Decoder_Input);
        m_div[k] = 0;
      end
      2: begin
        m_out[k] = inr ? (16'h0001 << Decoder_Input) : 16'h0000;
        if (inr) m_idx[k] = int'(Decoder_Input);
        m_div[k] = 0;
      end
      3: begin
        if (m_st[k] != 3) begin
          m_idx[k] = inr ? int'(Decoder_Input) : 0;
          m_div[k] = 0;
        end else if (inr) begin
          m_idx[k] = int'(Decoder_Input);
          m_div[k] = 0;
        end else if (m_div[k] == m_sd[k] - 1) begin
          m_div[k] = 0;
          m_idx[k] = (m_idx[k] == m_n[k] - 1) ? 0 : m_idx[k] + 1;
        end else begin
          m_div[k] = m_div[k] + 1;
        end
        m_out[k] = 16'h0001 << m_idx[k];
      end
      default: begin
        m_out[k] = 16'h0000;
        m_div[k] = 0;
      end
    endcase
    m_st[k] = nxt;
  endtask

  task automatic push_expect();
    exp_t e;
    model_step(0);
    model_step(1);
    e.out0 = m_out[0]; e.idx0 = 4'(m_idx[0]); e.err0 = m_err[0];
    e.out1 = m_out[1]; e.idx1 = 4'(m_idx[1]); e.err1 = m_err[1];
    sb_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({phase, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({phase, ".out16"}, 32'(dout16), 32'(e.out0));
      chk({phase, ".vld16"}, 32'(vld16), 32'(e.out0 != 16'h0000));
      chk({phase, ".idx16"}, 32'(idx16), 32'(e.idx0));
      chk({phase, ".err16"}, 32'(err16), 32'(e.err0));
      chk({phase, ".out10"}, 32'(dout10), 32'(e.out1));
      chk({phase, ".vld10"}, 32'(vld10), 32'(e.out1 != 16'h0000));
      chk({phase, ".idx10"}, 32'(idx10), 32'(e.idx1));
      chk({phase, ".err10"}, 32'(err10), 32'(e.err1));
    end
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic cyc(input logic en, input logic [1:0] md, input logic ld, input logic [3:0] din);
    Enable = en; Mode = md; Load = ld; Decoder_Input = din;
    push_expect();
    @(posedge Clock);
    #1;
    pop_compare();
    @(negedge Clock);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".out16"}, 32'(dout16), 32'd0);
    chk({tag, ".vld16"}, 32'(vld16), 32'd0);
    chk({tag, ".idx16"}, 32'(idx16), 32'd0);
    chk({tag, ".err16"}, 32'(err16), 32'd0);
    chk({tag, ".out10"}, 32'(dout10), 32'd0);
    chk({tag, ".vld10"}, 32'(vld10), 32'd0);
    chk({tag, ".idx10"}, 32'(idx10), 32'd0);
    chk({tag, ".err10"}, 32'(err10), 32'd0);
  endtask

  initial begin
    m_n[0] = 16; m_sd[0] = 4;
    m_n[1] = 10; m_sd[1] = 2;
    model_reset();
    Reset = 1'b1; Enable = 1'b0; Mode = 2'b00; Load = 1'b0; Decoder_Input = 4'd0;
    #12;
    check_all_zero("reset");
    @(negedge Clock);
    Reset = 1'b0;

    // HOLD idx 9, held 10 cycles, then Enable low clears it.
    phase = "hold9";
    cyc(1'b1, 2'b00, 1'b1, 4'd9);
    chk("hold9.onehot16", 32'(dout16), 32'h0200);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b00, 1'b0, 4'd0);
    cyc(1'b0, 2'b00, 1'b0, 4'd0);

    // PULSE loads 3 then 4 back to back, then nothing.
    phase = "pulse";
    cyc(1'b1, 2'b01, 1'b1, 4'd3);
    chk("pulse.first", 32'(dout16), 32'h0008);
    cyc(1'b1, 2'b01, 1'b1, 4'd4);
    chk("pulse.second", 32'(dout16), 32'h0010);
    cyc(1'b1, 2'b01, 1'b0, 4'd0);
    cyc(1'b1, 2'b01, 1'b0, 4'd0);

    // SCAN load 8: the 10-output instance wraps 9 -> 0.
    phase = "scan8";
    cyc(1'b1, 2'b10, 1'b1, 4'd8);
    for (int i = 0; i < 9; i++) cyc(1'b1, 2'b10, 1'b0, 4'd0);
    phase = "scan_oor";
    cyc(1'b1, 2'b10, 1'b1, 4'd11);
    cyc(1'b1, 2'b10, 1'b0, 4'd0);
    cyc(1'b1, 2'b10, 1'b1, 4'd15);
    cyc(1'b1, 2'b10, 1'b0, 4'd0);

    // HOLD idx 5, then idx 12: out of range for 10 outputs, in range for 16.
    phase = "hold_oor";
    cyc(1'b1, 2'b00, 1'b1, 4'd5);
    cyc(1'b1, 2'b00, 1'b1, 4'd12);
    chk("hold_oor.idx10_kept", 32'(idx10), 32'd5);
    chk("hold_oor.onehot16", 32'(dout16), 32'h1000);
    cyc(1'b1, 2'b00, 1'b0, 4'd0);

    // HOLD -> PULSE with a simultaneous load of 2.
    phase = "hold2pulse";
    cyc(1'b1, 2'b00, 1'b1, 4'd7);
    cyc(1'b1, 2'b00, 1'b0, 4'd0);
    cyc(1'b1, 2'b01, 1'b1, 4'd2);
    chk("hold2pulse.onehot16", 32'(dout16), 32'h0004);
    cyc(1'b1, 2'b01, 1'b0, 4'd0);

    // Reserved mode behaves as idle and ignores Load.
    phase = "rsvd";
    cyc(1'b1, 2'b00, 1'b1, 4'd6);
    cyc(1'b1, 2'b11, 1'b1, 4'd1);
    cyc(1'b1, 2'b11, 1'b0, 4'd0);

    // Random traffic.
    phase = "random";
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset in the middle of a scan at index 5.
    phase = "scan_rst";
    cyc(1'b0, 2'b00, 1'b0, 4'd0);
    cyc(1'b1, 2'b10, 1'b1, 4'd3);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b10, 1'b0, 4'd0);
    chk("scan_rst.pre_idx10", 32'(idx10), 32'd5);
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    sb_q.delete();
    @(negedge Clock);
    Reset = 1'b0;
    phase = "post_rst";
    cyc(1'b1, 2'b10, 1'b0, 4'd0);
    cyc(1'b1, 2'b10, 1'b0, 4'd0);
    cyc(1'b1, 2'b00, 1'b1, 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
